// File: rtl/reg_cmd_master_if.sv
// Command/response byte streams plus the register-bus side of the command master.
interface reg_cmd_master_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               cmd_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [7:0]               rsp_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic [7:0]               read_data;
    logic                     reg_read;
    logic                     reg_write;
    logic                     reg_addrvalid;
    logic                     busy;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready, read_data,
        output cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, busy
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready, read_data,
        input  cmd_ready, rsp_data, rsp_valid, reg_address, reg_bytecnt,
               write_data, reg_read, reg_write, reg_addrvalid, busy
    );
endinterface

// File: rtl/reg_cmd_master.sv
// Byte-stream to register-bus initiator: writes strobe 1 cycle after byte accept, reads cost
// 3+ cycles/byte; cmd_ready drops outside IDLE/LEN/WR_DATA, responses hold until rsp_ready.
module reg_cmd_master #(
    parameter int pBYTECNT_SIZE = 7
) (
    input  logic             cwusb_clk,
    input  logic             reset_i,
    reg_cmd_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, LEN, WR_DATA, WR_DONE, RD_STROBE, RD_CAPTURE, RD_SEND
    } state_t;

    state_t                   state;
    logic [7:0]               idx;
    logic [7:0]               len;
    logic [7:0]               idx_inc;
    logic                     is_read;
    logic                     cmd_fire;

    logic                     cmd_ready_q;
    logic [7:0]               rsp_data_q;
    logic                     rsp_valid_q;
    logic [7:0]               reg_address_q;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q;
    logic [7:0]               write_data_q;
    logic                     reg_read_q;
    logic                     reg_write_q;
    logic                     reg_addrvalid_q;
    logic                     busy_q;

    assign cmd_fire = bus.cmd_valid & cmd_ready_q;
    assign idx_inc  = idx + 8'd1;

    always_ff @(posedge cwusb_clk or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            idx             <= 8'd0;
            len             <= 8'd0;
            is_read         <= 1'b0;
            cmd_ready_q     <= 1'b0;
            rsp_data_q      <= 8'd0;
            rsp_valid_q     <= 1'b0;
            reg_address_q   <= 8'd0;
            reg_bytecnt_q   <= '0;
            write_data_q    <= 8'd0;
            reg_read_q      <= 1'b0;
            reg_write_q     <= 1'b0;
            reg_addrvalid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            reg_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        reg_address_q <= {1'b0, bus.cmd_data[6:0]};
                        is_read       <= bus.cmd_data[7];
                        busy_q        <= 1'b1;
                        state         <= LEN;
                    end
                end
                LEN: begin
                    if (cmd_fire) begin
                        len <= bus.cmd_data;
                        idx <= 8'd0;
                        if (bus.cmd_data == 8'd0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            reg_addrvalid_q <= 1'b1;
                            if (is_read) begin
                                // Strobe is registered on entry so it is high during RD_STROBE.
                                cmd_ready_q   <= 1'b0;
                                reg_read_q    <= 1'b1;
                                reg_bytecnt_q <= '0;
                                state         <= RD_STROBE;
                            end else begin
                                state <= WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (cmd_fire) begin
                        reg_write_q   <= 1'b1;
                        write_data_q  <= bus.cmd_data;
                        reg_bytecnt_q <= idx[pBYTECNT_SIZE-1:0];
                        idx           <= idx_inc;
                        if (idx_inc == len) begin
                            cmd_ready_q <= 1'b0;
                            state       <= WR_DONE;
                        end
                    end
                end
                WR_DONE: begin
                    reg_addrvalid_q <= 1'b0;
                    busy_q          <= 1'b0;
                    cmd_ready_q     <= 1'b1;
                    state           <= IDLE;
                end
                RD_STROBE: begin
                    state <= RD_CAPTURE;
                end
                RD_CAPTURE: begin
                    // bytecnt is left untouched so the combinational FIFO read mux stays put.
                    rsp_data_q  <= bus.read_data;
                    rsp_valid_q <= 1'b1;
                    state       <= RD_SEND;
                end
                RD_SEND: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        idx         <= idx_inc;
                        if (idx_inc == len) begin
                            reg_addrvalid_q <= 1'b0;
                            busy_q          <= 1'b0;
                            cmd_ready_q     <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            reg_read_q    <= 1'b1;
                            reg_bytecnt_q <= idx_inc[pBYTECNT_SIZE-1:0];
                            state         <= RD_STROBE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.reg_address   = reg_address_q;
    assign bus.reg_bytecnt   = reg_bytecnt_q;
    assign bus.write_data    = write_data_q;
    assign bus.reg_read      = reg_read_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.reg_addrvalid = reg_addrvalid_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Directed bench for reg_cmd_master: a 7-bit bytecnt instance plus a 2-bit one for the wrap case.
module tb_reg_cmd_master;

    logic cwusb_clk;
    logic reset_i;

    reg_cmd_master_if #(.pBYTECNT_SIZE(7)) ifc ();
    reg_cmd_master_if #(.pBYTECNT_SIZE(2)) ifc2 ();

    reg_cmd_master #(.pBYTECNT_SIZE(7)) dut (
        .cwusb_clk (cwusb_clk),
        .reset_i   (reset_i),
        .bus       (ifc.master)
    );

    reg_cmd_master #(.pBYTECNT_SIZE(2)) dut2 (
        .cwusb_clk (cwusb_clk),
        .reset_i   (reset_i),
        .bus       (ifc2.master)
    );

    int tests = 0;
    int fails = 0;

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    // Register responder: data for a read strobe is bytecnt + 0x40, valid the next cycle.
    always @(posedge cwusb_clk) begin
        if (ifc.reg_read) ifc.read_data <= 8'h40 + {1'b0, ifc.reg_bytecnt};
    end
    assign ifc2.read_data = 8'h00;

    // Bus monitor, sampled 2 ns after each rising edge.
    logic [23:0] wq[$];
    int          wcyc[$];
    logic [1:0]  bq2[$];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, av_cnt = 0, last_rd = 0;
    bit prev_rv = 1'b0;
    bit both_bad = 1'b0, nav_bad = 1'b0, pend_bad = 1'b0, gap_bad = 1'b0;

    always begin
        @(posedge cwusb_clk);
        #2;
        cyc++;
        if (ifc.reg_addrvalid) av_cnt++;
        if (ifc.reg_write) begin
            wr_cnt++;
            wq.push_back({ifc.reg_address, 1'b0, ifc.reg_bytecnt, ifc.write_data});
            wcyc.push_back(cyc);
        end
        if (ifc.reg_read) begin
            rd_cnt++;
            last_rd = cyc;
        end
        if (ifc.reg_read && ifc.reg_write) both_bad = 1'b1;
        if ((ifc.reg_read || ifc.reg_write) && !ifc.reg_addrvalid) nav_bad = 1'b1;
        if (ifc.reg_read && ifc.rsp_valid) pend_bad = 1'b1;
        if (ifc.rsp_valid && !prev_rv && (cyc - last_rd != 2)) gap_bad = 1'b1;
        prev_rv = ifc.rsp_valid;
        if (ifc2.reg_write) bq2.push_back(ifc2.reg_bytecnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte from the falling edge until the DUT accepts it; returns on the next falling edge.
    task automatic push(input bit sel, input logic [7:0] b);
        int n = 0;
        if (sel) begin
            ifc2.cmd_valid = 1'b1;
            ifc2.cmd_data  = b;
        end else begin
            ifc.cmd_valid = 1'b1;
            ifc.cmd_data  = b;
        end
        while (!(sel ? ifc2.cmd_ready : ifc.cmd_ready) && n < 100) begin
            @(negedge cwusb_clk);
            n++;
        end
        check("cmd_accept_timeout", n < 100, 1);
        @(negedge cwusb_clk);
    endtask

    task automatic idle_cmd();
        ifc.cmd_valid  = 1'b0;
        ifc2.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!ifc.rsp_valid && n < 50) begin
            @(negedge cwusb_clk);
            n++;
        end
        check("rsp_valid_timeout", n < 50, 1);
    endtask

    function automatic logic [23:0] outs_a();
        return {ifc.rsp_data, ifc.reg_address, ifc.write_data};
    endfunction

    function automatic logic [12:0] outs_b();
        return {ifc.cmd_ready, ifc.rsp_valid, ifc.reg_bytecnt, ifc.reg_read,
                ifc.reg_write, ifc.reg_addrvalid, ifc.busy};
    endfunction

    int rd0, wr0, av0;

    initial begin
        reset_i = 1'b1;
        ifc.cmd_valid = 1'b0;  ifc.cmd_data = 8'h00;  ifc.rsp_ready = 1'b0;
        ifc2.cmd_valid = 1'b0; ifc2.cmd_data = 8'h00; ifc2.rsp_ready = 1'b1;
        repeat (3) @(negedge cwusb_clk);

        // Reset state
        check("reset_outs_a", outs_a(), 0);
        check("reset_outs_b", outs_b(), 0);
        reset_i = 1'b0;
        check("cmd_ready_at_release", ifc.cmd_ready, 0);
        @(negedge cwusb_clk);
        check("cmd_ready_after_release", ifc.cmd_ready, 1);

        // Write 0x0A, N=3, cmd_valid held high
        push(0, 8'h0A);
        push(0, 8'h03);
        check("wr_addrvalid_after_len", ifc.reg_addrvalid, 1);
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        idle_cmd();
        check("wr_last_strobe", ifc.reg_write, 1);
        check("wr_done_addrvalid", ifc.reg_addrvalid, 1);
        check("wr_done_cmd_ready", ifc.cmd_ready, 0);
        @(negedge cwusb_clk);
        check("wr_end_strobe", ifc.reg_write, 0);
        check("wr_end_addrvalid", ifc.reg_addrvalid, 0);
        check("wr_end_busy", ifc.busy, 0);
        check("wr_end_cmd_ready", ifc.cmd_ready, 1);
        check("wr_count", wq.size(), 3);
        if (wq.size() == 3) begin
            check("wr_byte0", wq[0], 24'h0A_00_11);
            check("wr_byte1", wq[1], 24'h0A_01_22);
            check("wr_byte2", wq[2], 24'h0A_02_33);
            check("wr_back_to_back", wcyc[2] - wcyc[0], 2);
        end

        // Read 0x81, N=4 with rsp_ready backpressure
        rd0 = rd_cnt;
        push(0, 8'h81);
        push(0, 8'h04);
        idle_cmd();
        check("rd_addr", ifc.reg_address, 8'h01);
        for (int i = 0; i < 4; i++) begin
            wait_rsp();
            repeat (i % 2 + 1) @(negedge cwusb_clk);
            check("rd_hold_valid", ifc.rsp_valid, 1);
            check("rd_data", ifc.rsp_data, 8'h40 + i);
            ifc.rsp_ready = 1'b1;
            @(negedge cwusb_clk);
            ifc.rsp_ready = 1'b0;
        end
        check("rd_strobe_count", rd_cnt - rd0, 4);
        check("rd_end_busy", ifc.busy, 0);
        check("rd_end_addrvalid", ifc.reg_addrvalid, 0);
        check("rd_valid_gap", gap_bad, 0);
        check("rd_no_strobe_pending", pend_bad, 0);

        // Null command
        rd0 = rd_cnt; wr0 = wr_cnt; av0 = av_cnt;
        push(0, 8'h05);
        push(0, 8'h00);
        idle_cmd();
        check("null_busy", ifc.busy, 0);
        check("null_cmd_ready", ifc.cmd_ready, 1);
        repeat (3) @(negedge cwusb_clk);
        check("null_addrvalid_cycles", av_cnt - av0, 0);
        check("null_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Bytecnt wrap on the 2-bit instance, N=6
        push(1, 8'h03);
        push(1, 8'h06);
        for (int i = 0; i < 6; i++) push(1, 8'hA0 + i[7:0]);
        idle_cmd();
        repeat (2) @(negedge cwusb_clk);
        check("wrap_count", bq2.size(), 6);
        if (bq2.size() == 6) begin
            check("wrap_seq", {bq2[0], bq2[1], bq2[2], bq2[3], bq2[4], bq2[5]},
                  {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1});
        end

        // Reset during RD_SEND of byte 1
        rd0 = rd_cnt;
        push(0, 8'h81);
        push(0, 8'h04);
        idle_cmd();
        wait_rsp();
        ifc.rsp_ready = 1'b1;
        @(negedge cwusb_clk);
        ifc.rsp_ready = 1'b0;
        wait_rsp();
        check("mid_rd_data1", ifc.rsp_data, 8'h41);
        reset_i = 1'b1;
        #1;
        check("async_rst_outs_a", outs_a(), 0);
        check("async_rst_outs_b", outs_b(), 0);
        repeat (3) @(negedge cwusb_clk);
        reset_i = 1'b0;
        repeat (4) @(negedge cwusb_clk);
        check("rst_no_more_reads", rd_cnt - rd0, 2);
        check("rst_idle_ready", ifc.cmd_ready, 1);
        push(0, 8'h22);
        push(0, 8'h01);
        push(0, 8'h5A);
        idle_cmd();
        repeat (2) @(negedge cwusb_clk);
        check("post_rst_wr_count", wq.size(), 4);
        if (wq.size() == 4) check("post_rst_wr", wq[3], 24'h22_00_5A);

        check("never_both_strobes", both_bad, 0);
        check("never_strobe_without_addrvalid", nav_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
